// File: rtl/exec_unit.sv
// exec_unit: RV32 execute stage. Computes the 32-bit integer ALU result from
// decoded op fields and selected operands. Shifts use a one-bit-per-cycle
// serial shifter by default. Results are held in a single-entry output
// register with a valid/ready handshake toward memory/writeback.
//
// Build option: define EXEC_FAST_SHIFT_EN to replace the serial shifter with a
// single-cycle barrel shifter (every op then has latency 1).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (transfer on in_valid && in_ready)
//   exec_op           {funct7[5], funct3}
//   operand1_sel      0 = rs1_val, 1 = pc
//   operand2_sel      0 = rs2_val, 1 = imm
//   rs1_val, rs2_val, pc, imm   operand sources, sampled on accept only
//   out_valid/out_ready downstream handshake
//   result            ALU result
//
// state   | meaning
// S_IDLE  | can accept; result register may still hold an unconsumed result
// S_SHIFT | serial shift in progress, one bit per cycle, count = bits left
module exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      exec_op,
  input  logic            operand1_sel,
  input  logic            operand2_sel,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] op1, op2, alu_res, res_next;
  logic [2:0]      funct3;
  logic            alt;
  logic [4:0]      shamt;
  logic            is_shift;
  logic            res_load;

  assign op1      = operand1_sel ? pc : rs1_val;
  assign op2      = operand2_sel ? imm : rs2_val;
  assign funct3   = exec_op[2:0];
  // funct7[5] only distinguishes SUB and SRA; elsewhere it is ignored.
  assign alt      = exec_op[3] & ((funct3 == 3'b000) | (funct3 == 3'b101));
  assign shamt    = op2[4:0];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = alt ? (op1 - op2) : (op1 + op2);
`ifdef EXEC_FAST_SHIFT_EN
      3'b001: alu_res = op1 << shamt;
      3'b101: begin
        if (alt) alu_res = $signed(op1) >>> shamt;
        else     alu_res = op1 >> shamt;
      end
`else
      // Only used with shamt == 0; nonzero shifts go through the serial path.
      3'b001, 3'b101: alu_res = op1;
`endif
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      3'b100: alu_res = op1 ^ op2;
      3'b110: alu_res = op1 | op2;
      default: alu_res = op1 & op2;
    endcase
  end

`ifdef EXEC_FAST_SHIFT_EN
  assign in_ready = !out_valid || out_ready;
  assign res_load = in_valid && in_ready;
  assign res_next = alu_res;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] sh_val, sh_val_d, sh_step;
  logic [4:0]      count, count_d;
  logic            sh_left, sh_left_d, sh_arith, sh_arith_d;

  assign sh_step = sh_left ? {sh_val[XLEN-2:0], 1'b0}
                           : {sh_arith & sh_val[XLEN-1], sh_val[XLEN-1:1]};

  always_comb begin
    state_d    = state;
    in_ready   = 1'b0;
    res_load   = 1'b0;
    res_next   = alu_res;
    sh_val_d   = sh_val;
    count_d    = count;
    sh_left_d  = sh_left;
    sh_arith_d = sh_arith;
    case (state)
      S_IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready)) begin
          if (is_shift && (shamt != 5'd0)) begin
            sh_val_d   = op1;
            count_d    = shamt;
            sh_left_d  = (funct3 == 3'b001);
            sh_arith_d = alt;
            state_d    = S_SHIFT;
          end else begin
            res_load = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        sh_val_d = sh_step;
        count_d  = count - 5'd1;
        if (count == 5'd1) begin
          res_load = 1'b1;
          res_next = sh_step;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sh_val   <= '0;
      count    <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else begin
      state    <= state_d;
      sh_val   <= sh_val_d;
      count    <= count_d;
      sh_left  <= sh_left_d;
      sh_arith <= sh_arith_d;
    end
  end
`endif

  // A load on the same edge as a consume keeps out_valid high with new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      result    <= res_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
